// File: rtl/vip_stream_pkg.sv
// Shared types and constants for the VIP synthetic video stream generator.
package vip_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VS,
        S_VBP,
        S_ACT,
        S_VFP
    } state_t;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_FLAT  = 2'd3;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/vip_pattern_lut.sv
// Combinational test-pattern generator: pixel value from pattern code, position and frame count.
module vip_pattern_lut
    import vip_stream_pkg::*;
(
    input  logic [1:0] pattern,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] frame_cnt,
    output logic [7:0] pix
);

    always_comb begin
        pix = 8'h00;
        case (pattern)
            PAT_HRAMP: pix = x;
            PAT_VRAMP: pix = y;
            PAT_CHECK: pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            PAT_FLAT:  pix = frame_cnt;
            default:   pix = 8'h00;
        endcase
    end

endmodule

// File: rtl/vip_video_stream_gen.sv
// Synthetic vsync/href/clken/Y frame source with programmable geometry and pixel rate.
module vip_video_stream_gen
    import vip_stream_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int H_BLANK   = 160,
    parameter int VS_LINES  = 2,
    parameter int VBP_LINES = 33,
    parameter int VFP_LINES = 10,
    parameter int CLKEN_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       per_frame_vsync,
    output logic       per_frame_href,
    output logic       per_frame_clken,
    output logic [7:0] per_img_y,
    output logic       frame_done,
    output logic [7:0] frame_cnt,
    output logic       busy
);

    localparam int     H_TOTAL     = IMG_W + H_BLANK;
    localparam int     LINE_MAX    = max4(VS_LINES, VBP_LINES, IMG_H, VFP_LINES);
    localparam int     HW          = $clog2(H_TOTAL);
    localparam int     LW          = $clog2(LINE_MAX);
    localparam int     DW          = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;
    localparam state_t FIRST_STATE = (VS_LINES == 0) ? S_VBP : S_VS;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [LW-1:0] line_cnt;
    logic [1:0]    pat_q;
    logic          tick;
    logic          line_end;
    logic          last_line;
    logic          state_done;
    logic          frame_end;
    logic          act_pix;
    logic [7:0]    pix;

    assign tick       = (div_cnt == DW'(CLKEN_DIV - 1));
    assign line_end   = tick && (h_cnt == HW'(H_TOTAL - 1));
    assign state_done = line_end && last_line;
    assign act_pix    = (state == S_ACT) && (h_cnt < HW'(IMG_W));

    // Each timing phase lasts a whole number of lines; leave it on the last line's wrap tick.
    always_comb begin
        state_nxt = state;
        last_line = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) state_nxt = FIRST_STATE;
            end
            S_VS: begin
                last_line = (line_cnt == LW'(VS_LINES - 1));
                if (state_done) state_nxt = S_VBP;
            end
            S_VBP: begin
                last_line = (line_cnt == LW'(VBP_LINES - 1));
                if (state_done) state_nxt = S_ACT;
            end
            S_ACT: begin
                last_line = (line_cnt == LW'(IMG_H - 1));
                if (state_done) state_nxt = S_VFP;
            end
            S_VFP: begin
                last_line = (line_cnt == LW'(VFP_LINES - 1));
                if (state_done) begin
                    frame_end = 1'b1;
                    state_nxt = enable ? FIRST_STATE : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            h_cnt    <= '0;
            line_cnt <= '0;
            pat_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                div_cnt  <= '0;
                h_cnt    <= '0;
                line_cnt <= '0;
                if (enable) pat_q <= pattern_sel;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) h_cnt <= line_end ? '0 : h_cnt + 1'b1;
                if (line_end) line_cnt <= last_line ? '0 : line_cnt + 1'b1;
            end
        end
    end

    vip_pattern_lut u_lut (
        .pattern   (pat_q),
        .x         (8'(h_cnt)),
        .y         (8'(line_cnt)),
        .frame_cnt (frame_cnt),
        .pix       (pix)
    );

    // Outputs trail the state/counters by one clock; Y only moves on an active pixel strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_frame_vsync <= 1'b0;
            per_frame_href  <= 1'b0;
            per_frame_clken <= 1'b0;
            per_img_y       <= 8'h00;
            frame_done      <= 1'b0;
            frame_cnt       <= 8'h00;
            busy            <= 1'b0;
        end else begin
            per_frame_vsync <= (state == S_VS);
            per_frame_href  <= act_pix;
            per_frame_clken <= act_pix && tick;
            if (act_pix && tick) per_img_y <= pix;
            frame_done      <= frame_end;
            if (frame_end) frame_cnt <= frame_cnt + 8'd1;
            busy            <= (state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_vip_video_stream_gen.sv
// Self-checking bench: several geometries run side by side, compared slot-by-slot with a frame-timeline model.
module tb_vip_video_stream_gen;

    localparam int NCFG = 4;
    localparam int P_W   [NCFG] = '{4, 4, 16, 5};
    localparam int P_H   [NCFG] = '{3, 3, 16, 2};
    localparam int P_HB  [NCFG] = '{2, 2, 3, 1};
    localparam int P_VS  [NCFG] = '{1, 1, 2, 0};
    localparam int P_VBP [NCFG] = '{1, 1, 2, 1};
    localparam int P_VFP [NCFG] = '{1, 1, 2, 1};
    localparam int P_DIV [NCFG] = '{1, 2, 1, 3};

    typedef struct packed {
        logic       vsync;
        logic       href;
        logic       clken;
        logic [7:0] y;
        logic       done;
        logic [7:0] fcnt;
        logic       busy;
    } out_t;

    typedef struct {
        int cfg;
        int pat;
        int frames;
        int drop;
        int rst_slot;
        int exp_clken;
        int exp_href;
        int exp_done;
    } run_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] pattern_sel;
    out_t       dut_out [NCFG];
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        logic       vs, hr, ce, fd, bz;
        logic [7:0] y, fc;
        vip_video_stream_gen #(
            .IMG_W     (P_W[g]),
            .IMG_H     (P_H[g]),
            .H_BLANK   (P_HB[g]),
            .VS_LINES  (P_VS[g]),
            .VBP_LINES (P_VBP[g]),
            .VFP_LINES (P_VFP[g]),
            .CLKEN_DIV (P_DIV[g])
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .enable          (enable),
            .pattern_sel     (pattern_sel),
            .per_frame_vsync (vs),
            .per_frame_href  (hr),
            .per_frame_clken (ce),
            .per_img_y       (y),
            .frame_done      (fd),
            .frame_cnt       (fc),
            .busy            (bz)
        );
        assign dut_out[g] = {vs, hr, ce, y, fd, fc, bz};
    end

    function automatic int frame_len(input int c);
        return (P_VS[c] + P_VBP[c] + P_H[c] + P_VFP[c]) * (P_W[c] + P_HB[c]) * P_DIV[c];
    endfunction

    // Expected outputs for timeline slot k (k = clocks since the frame sequence began).
    function automatic out_t expect_slot(input int c, input int pat, input int k, input int n,
                                         input logic [7:0] prev_y);
        out_t e;
        int   spl, len, f, s, line, h, ay;
        bit   tick;
        spl    = (P_W[c] + P_HB[c]) * P_DIV[c];
        len    = frame_len(c);
        e      = '0;
        e.y    = prev_y;
        if (k >= n * len) begin
            e.fcnt = 8'(n);
            return e;
        end
        f       = k / len;
        s       = k % len;
        line    = s / spl;
        h       = (s % spl) / P_DIV[c];
        tick    = (s % P_DIV[c]) == P_DIV[c] - 1;
        ay      = line - P_VS[c] - P_VBP[c];
        e.vsync = line < P_VS[c];
        e.href  = (ay >= 0) && (ay < P_H[c]) && (h < P_W[c]);
        e.clken = e.href && tick;
        if (e.clken) begin
            case (pat)
                0:       e.y = 8'(h);
                1:       e.y = 8'(ay);
                2:       e.y = (((h >> 3) ^ (ay >> 3)) & 1) != 0 ? 8'hFF : 8'h00;
                default: e.y = 8'(f);
            endcase
        end
        e.done = (s == len - 1);
        e.fcnt = 8'((k + 1) / len);
        e.busy = 1'b1;
        return e;
    endfunction

    task automatic checkOutput(input string name, input out_t got, input out_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got vs=%b hr=%b ce=%b y=%h fd=%b fc=%0d busy=%b, expected vs=%b hr=%b ce=%b y=%h fd=%b fc=%0d busy=%b",
                      name, got.vsync, got.href, got.clken, got.y, got.done, got.fcnt, got.busy,
                      exp.vsync, exp.href, exp.clken, exp.y, exp.done, exp.fcnt, exp.busy);
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic resetAndStart(input int c, input string tag);
        rst    = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;
        checkOutput({tag, " reset"}, dut_out[c], '0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, " start"}, dut_out[c], '0);
    endtask

    task automatic applyStimulus(input int idx, input run_t r);
        int         len, total, drop_abs, k, n_clken, n_href, n_done;
        logic       prev_href;
        logic [7:0] last_y;
        bit         restarted;
        out_t       got, exp;
        string      tag;
        tag         = $sformatf("run%0d", idx);
        len         = frame_len(r.cfg);
        total       = r.frames * len;
        drop_abs    = total - len + r.drop;
        pattern_sel = 2'(r.pat);
        resetAndStart(r.cfg, tag);
        k = 0; n_clken = 0; n_href = 0; n_done = 0;
        prev_href = 1'b0; last_y = 8'h00; restarted = 1'b0;
        while (k < total + 3) begin
            @(posedge clk); #1;
            got = dut_out[r.cfg];
            exp = expect_slot(r.cfg, r.pat, k, r.frames, last_y);
            checkOutput($sformatf("%s slot%0d", tag, k), got, exp);
            last_y = exp.y;
            if (got.clken) n_clken++;
            if (got.href && !prev_href) n_href++;
            if (got.done) n_done++;
            prev_href = got.href;
            if (!restarted && k == r.rst_slot) begin
                resetAndStart(r.cfg, {tag, " midframe"});
                restarted = 1'b1;
                k = 0; n_clken = 0; n_href = 0; n_done = 0;
                prev_href = 1'b0; last_y = 8'h00;
                continue;
            end
            if (k == drop_abs) enable = 1'b0;
            k++;
        end
        checkCount({tag, " clken count"}, n_clken, r.exp_clken);
        checkCount({tag, " href pulses"}, n_href, r.exp_href);
        checkCount({tag, " frame_done pulses"}, n_done, r.exp_done);
    endtask

    initial begin
        run_t runs [$];
        run_t r;
        rst         = 1'b1;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        //                cfg pat frm drop rst  clken href done
        runs.push_back('{0,  0,  2,  0,   -1,  24,   6,   2});
        runs.push_back('{1,  1,  1,  0,   -1,  12,   3,   1});
        runs.push_back('{2,  2,  1,  0,   -1,  256,  16,  1});
        runs.push_back('{0,  3,  3,  0,   -1,  36,   9,   3});
        runs.push_back('{0,  0,  2,  24,  -1,  24,   6,   2});
        runs.push_back('{0,  0,  1,  30,  19,  12,   3,   1});
        runs.push_back('{3,  2,  2,  0,   -1,  20,   4,   2});
        for (int i = 0; i < 8; i++) begin
            r.cfg       = int'($urandom_range(0, NCFG - 1));
            r.pat       = int'($urandom_range(0, 3));
            r.frames    = int'($urandom_range(1, 2));
            r.drop      = int'($urandom_range(0, frame_len(r.cfg) - 2));
            r.rst_slot  = -1;
            r.exp_clken = P_W[r.cfg] * P_H[r.cfg] * r.frames;
            r.exp_href  = P_H[r.cfg] * r.frames;
            r.exp_done  = r.frames;
            runs.push_back(r);
        end
        for (int i = 0; i < runs.size(); i++) applyStimulus(i, runs[i]);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
